// File: rtl/cdc_in_arbiter.sv
// cdc_in_arbiter: round-robin arbiter that shares the single usb_cdc IN byte
// stream between N_REQ application byte sources. Each grant carries at most
// BURST_LEN bytes, which maps one burst onto one IN bulk packet.
//
// Optional feature: define CDC_ARB_LOCK_EN to add lock_i. A locked requester
// keeps its grant past BURST_LEN bytes until it drops valid, so a message
// spanning several packets is not interleaved with other sources.
module cdc_in_arbiter #(
  parameter int N_REQ     = 2,
  parameter int BURST_LEN = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
`ifdef CDC_ARB_LOCK_EN
  input  logic [N_REQ-1:0]     lock_i,
`endif
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state;
  // Most recently granted requester; while in XFER it is also the granted index.
  logic [IDX_W-1:0]  last;
  logic [CNT_W-1:0]  cnt;

  logic [IDX_W-1:0]  sel;
  logic              sel_vld;
  logic [IDX_W-1:0]  idx;

  logic              hs;
  logic              lock_g;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              burst_done;
  logic              rel;

  // Byte counter increment that holds at BURST_LEN. Only a locked burst can
  // keep handshaking once BURST_LEN is reached, and it must not wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c >= CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = c + CNT_W'(1);
    end
    return r;
  endfunction

  // One-hot decode of a requester index into a grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

`ifdef CDC_ARB_LOCK_EN
  assign lock_g = lock_i[last];
`else
  assign lock_g = 1'b0;
`endif

  // Round-robin search: the first valid requester after the last grant wins.
  always_comb begin
    sel     = last;
    sel_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDX_W'((int'(last) + i) % N_REQ);
      if (!sel_vld && req_valid_i[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  // A byte is accepted only when the granted source is valid and usb_cdc is ready.
  assign hs         = (state == XFER) & req_valid_i[last] & in_ready_i;
  assign cnt_nxt    = sat_inc(cnt);
  // The byte that fills the burst ends the grant unless the source holds its lock.
  assign burst_done = hs & (cnt_nxt == CNT_MAX) & ~lock_g;
  // A source that drops valid gives up the rest of its burst.
  assign rel        = (state == XFER) & (~req_valid_i[last] | burst_done);

  // Zero-latency pass-through of the granted source; everything is quiet in IDLE.
  always_comb begin
    in_data_o   = '0;
    in_valid_o  = 1'b0;
    req_ready_o = '0;
    if (state == XFER) begin
      in_data_o         = req_data_i[{last, 3'b000} +: 8];
      in_valid_o        = req_valid_i[last];
      req_ready_o[last] = in_ready_i;
    end
  end

  // Grant FSM: arbitrate in IDLE, count bytes in XFER, drop back on release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      grant_o <= '0;
      busy_o  <= 1'b0;
      last    <= LAST_RST;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            state   <= XFER;
            grant_o <= onehot(sel);
            busy_o  <= 1'b1;
            last    <= sel;
            cnt     <= '0;
          end
        end
        XFER: begin
          if (rel) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
            cnt     <= '0;
          end else if (hs) begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Directed testbench for cdc_in_arbiter with N_REQ=2, BURST_LEN=8.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_cdc_in_arbiter;

  localparam int N  = 2;
  localparam int BL = 8;

  logic          clk;
  logic          rstn_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]  req_valid_i;
  logic [N-1:0]  req_ready_o;
  logic [N-1:0]  lock_i;
  logic [7:0]    in_data_o;
  logic          in_valid_o;
  logic          in_ready_i;
  logic [N-1:0]  grant_o;
  logic          busy_o;

  int checks;
  int failures;

  cdc_in_arbiter #(.N_REQ(N), .BURST_LEN(BL)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
`ifdef CDC_ARB_LOCK_EN
    .lock_i      (lock_i),
`endif
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn_i      = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    in_ready_i  = 1'b0;
    lock_i      = '0;
    @(negedge clk);
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_in_valid", in_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_in_data", in_data_o, 0);
    @(negedge clk);
    rstn_i = 1'b1;
  endtask

  int  n0, n1, m, obs_hs;
  bit  eb, ev;
  int  eg, ed;

  initial begin
    checks      = 0;
    failures    = 0;
    rstn_i      = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    in_ready_i  = 1'b0;
    lock_i      = '0;

    // ---- single requester, 20 bytes back-to-back ----
    do_reset();
    n0 = 0;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      req_valid_i = {1'b0, n0 < 20};
      req_data_i  = {8'h00, 8'(n0)};
      in_ready_i  = 1'b1;
      #1;
      eb = (c < 24) && (c % 9 != 0);
      ev = eb && (n0 < 20);
      chk($sformatf("t1_busy_c%0d", c), busy_o, eb);
      chk($sformatf("t1_grant_c%0d", c), grant_o, eb ? 1 : 0);
      chk($sformatf("t1_valid_c%0d", c), in_valid_o, ev);
      if (ev) begin
        chk($sformatf("t1_data_c%0d", c), in_data_o, n0);
        n0++;
      end
    end

    // ---- two saturated requesters alternate 8-byte bursts ----
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int c = 0; c <= 35; c++) begin
      @(negedge clk);
      req_valid_i = 2'b11;
      req_data_i  = {8'(8'h80 + n1), 8'(n0)};
      in_ready_i  = 1'b1;
      #1;
      eb = (c % 9 != 0);
      eg = ((c / 9) % 2 == 0) ? 1 : 2;
      chk($sformatf("t2_busy_c%0d", c), busy_o, eb);
      chk($sformatf("t2_grant_c%0d", c), grant_o, eb ? eg : 0);
      chk($sformatf("t2_ready_c%0d", c), req_ready_o, eb ? eg : 0);
      if (eb) begin
        ed = (eg == 1) ? n0 : (8'h80 + n1);
        chk($sformatf("t2_data_c%0d", c), in_data_o, ed);
        if (eg == 1) n0++; else n1++;
      end
    end

    // ---- backpressure: ready toggles every cycle ----
    do_reset();
    n0 = 0;
    obs_hs = 0;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      req_valid_i = 2'b01;
      req_data_i  = {8'h00, 8'(8'h20 + n0)};
      in_ready_i  = c[0];
      #1;
      eb = (c >= 1) && (c <= 15);
      chk($sformatf("t3_busy_c%0d", c), busy_o, eb);
      chk($sformatf("t3_grant_c%0d", c), grant_o, eb ? 1 : 0);
      chk($sformatf("t3_ready_c%0d", c), req_ready_o, eb ? (c & 1) : 0);
      if (eb) begin
        chk($sformatf("t3_data_c%0d", c), in_data_o, 8'h20 + n0);
        if (c[0]) n0++;
      end
      if (in_valid_o && in_ready_i) obs_hs++;
    end
    chk("t3_handshakes", obs_hs, 8);

    // ---- early release: req 1 stops after 3 bytes, req 0 waiting ----
    do_reset();
    n0 = 0;
    m  = 0;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      req_valid_i = {c <= 3, (c >= 1) && (n0 < 8)};
      req_data_i  = {8'(8'hA0 + m), 8'(n0)};
      in_ready_i  = 1'b1;
      #1;
      eb = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 13));
      eg = (c <= 4) ? 2 : 1;
      ev = ((c >= 1) && (c <= 3)) || ((c >= 6) && (c <= 13));
      chk($sformatf("t4_busy_c%0d", c), busy_o, eb);
      chk($sformatf("t4_grant_c%0d", c), grant_o, eb ? eg : 0);
      chk($sformatf("t4_valid_c%0d", c), in_valid_o, ev);
      if (ev) begin
        chk($sformatf("t4_data_c%0d", c), in_data_o, (eg == 2) ? (8'hA0 + m) : n0);
        if (eg == 2) m++; else n0++;
      end
    end

    // ---- reset in the middle of a req 1 burst ----
    do_reset();
    n1 = 0;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      req_valid_i = 2'b10;
      req_data_i  = {8'(8'h40 + n1), 8'h00};
      in_ready_i  = 1'b1;
      #1;
      eb = (c >= 1);
      chk($sformatf("t5_grant_c%0d", c), grant_o, eb ? 2 : 0);
      if (eb) begin
        chk($sformatf("t5_data_c%0d", c), in_data_o, 8'h40 + n1);
        n1++;
      end
    end
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    chk("t5_mid_grant", grant_o, 0);
    chk("t5_mid_busy", busy_o, 0);
    chk("t5_mid_valid", in_valid_o, 0);
    chk("t5_mid_ready", req_ready_o, 0);
    chk("t5_mid_data", in_data_o, 0);
    @(negedge clk);
    req_valid_i = 2'b11;
    rstn_i      = 1'b1;
    #1;
    chk("t5_post_idle_grant", grant_o, 0);
    @(negedge clk);
    #1;
    chk("t5_post_grant", grant_o, 1);
    chk("t5_post_busy", busy_o, 1);

`ifdef CDC_ARB_LOCK_EN
    // ---- locked 20-byte message from req 0 while req 1 waits ----
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      req_valid_i = {1'b1, n0 < 20};
      lock_i      = {1'b0, n0 < 20};
      req_data_i  = {8'(8'hC0 + n1), 8'(n0)};
      in_ready_i  = 1'b1;
      #1;
      eb = ((c >= 1) && (c <= 21)) || (c == 23);
      eg = (c <= 21) ? 1 : 2;
      ev = ((c >= 1) && (c <= 20)) || (c == 23);
      chk($sformatf("t6_busy_c%0d", c), busy_o, eb);
      chk($sformatf("t6_grant_c%0d", c), grant_o, eb ? eg : 0);
      chk($sformatf("t6_valid_c%0d", c), in_valid_o, ev);
      if (ev) begin
        chk($sformatf("t6_data_c%0d", c), in_data_o, (eg == 1) ? n0 : (8'hC0 + n1));
        if (eg == 1) n0++; else n1++;
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_in_arbiter.md
# cdc_in_arbiter

Round-robin arbiter that shares the single `usb_cdc` IN byte stream (device-to-host) between up to four application-side byte sources. It sits between the application producers and `usb_cdc`'s `in_data_i`/`in_valid_i`/`in_ready_o` handshake, in the `app_clk_i` domain. Grants are held for bursts of at most `BURST_LEN` bytes, so one source cannot starve the others, and each burst maps to one IN bulk packet.

## Interface
- `N_REQ`, 2: number of requesters, legal range 2..4.
- `BURST_LEN`, 8: maximum bytes per grant, legal range 1..64; set equal to `IN_BULK_MAXPACKETSIZE`.

- `clk_i`  in  1  clock; same as the `usb_cdc` `app_clk_i`.
- `rstn_i`  in  1  reset; asynchronous, active-low.
- `req_data_i`  in  8*N_REQ  requester bytes; requester k uses bits [8k+7:8k].
- `req_valid_i`  in  N_REQ  per-requester byte valid.
- `req_ready_o`  out  N_REQ  per-requester ready; only the granted bit can be 1.
- `in_data_o`  out  8  to `usb_cdc` `in_data_i`.
- `in_valid_o`  out  1  to `usb_cdc` `in_valid_i`.
- `in_ready_i`  in  1  from `usb_cdc` `in_ready_o`.
- `grant_o`  out  N_REQ  one-hot registered grant; all zero when idle.
- `busy_o`  out  1  1 while in state XFER.

## Operation
- States:
  - IDLE: `grant_o`=0; all `req_ready_o`=0; `in_valid_o`=0.
    - If any `req_valid_i` is set, select the first valid requester searching from `last+1` modulo N_REQ.
    - Register the selection into `grant_o` and `last`, clear `cnt`, go to XFER.
  - XFER (granted index g):
    - Combinational pass-through: `in_data_o`=req_data_i[g], `in_valid_o`=req_valid_i[g], `req_ready_o[g]`=in_ready_i.
    - Handshake is `req_valid_i[g] & in_ready_i`; each handshake increments `cnt`.
    - Release to IDLE at the clock edge on which either:
      - a handshake brings `cnt` to BURST_LEN, or
      - `req_valid_i[g]`=0.
- Stall: `req_valid_i[g]`=1 with `in_ready_i`=0 holds the grant; `cnt` does not change. Requesters must hold data stable while valid is high and not accepted.
- Simultaneous events:
  - The last burst byte being accepted while the requester's valid stays high still releases the grant.
  - The requester then re-enters arbitration behind any other valid requester.
- `cnt` width is clog2(BURST_LEN+1); `cnt` never exceeds BURST_LEN.
- `last` is updated only on a grant, so the round-robin order persists across idle periods.
- Reset mid-burst: immediate return to IDLE; `cnt`=0; `last`=N_REQ-1; any byte in flight is dropped, and the requester is not told.

## Timing
- Reset values:
  - `grant_o`=0, `busy_o`=0, `in_valid_o`=0, `req_ready_o`=0, `in_data_o`=0.
  - `last`=N_REQ-1, so requester 0 wins the first arbitration.
- Arbitration latency: valid seen in IDLE at cycle t -> `grant_o` set and first transfer possible at cycle t+1.
- Release to next grant: one IDLE cycle. Worst-case throughput is BURST_LEN bytes per BURST_LEN+1 cycles.
- `in_valid_o`, `in_data_o` and `req_ready_o` are combinational from inputs plus registered grant state. There is no added pipeline latency in XFER.
- `grant_o` and `busy_o` are registered and change only on clock edges or reset.

## Configuration
- `CDC_ARB_LOCK_EN` defined:
  - Adds input `lock_i` [N_REQ-1:0].
  - While `lock_i[g]`=1, the BURST_LEN release is suppressed and `cnt` saturates at BURST_LEN.
  - Release happens only when `req_valid_i[g]`=0. This allows multi-packet atomic messages.
- Undefined: no `lock_i` port; release follows only the two XFER rules above.

## Test plan
- Single requester: req 0 presents 20 bytes 0x00..0x13 back-to-back, `in_ready_i`=1.
  - Output is 0x00..0x13 in order, with one IDLE gap after bytes 8 and 16.
  - `grant_o`=01 for every burst.
- Two saturated requesters, N_REQ=2, BURST_LEN=8: the sequence is 8 bytes from req 0, gap, 8 from req 1, gap, 8 from req 0, and so on. No byte is lost or duplicated.
- Backpressure: `in_ready_i` toggles 1/0 each cycle during a burst.
  - Exactly 8 handshakes occur per grant.
  - `in_data_o` is stable while not ready.
  - `grant_o` is held through stalls.
- Early release: req 1 drops valid after 3 bytes while req 0 is waiting -> grant moves to req 0 after one IDLE cycle; `cnt` restarts at 0.
- Reset mid-burst: assert `rstn_i` low after byte 4 of a req 1 burst -> all outputs are 0 immediately; after release, req 0 wins the first arbitration.
- With `CDC_ARB_LOCK_EN`: req 0 holds `lock_i[0]`=1 for 20 bytes while req 1 is valid -> 20 contiguous req 0 bytes, then req 1 is granted.
